// File: rtl/ft245_sync_responder_if.sv
// FT245-style synchronous FIFO bus between the FPGA-side bridge (master)
// and the device-end responder (slave).
interface ft245_sync_responder_if;
  logic       ftdi_rxfn;
  logic       ftdi_txen;
  logic       ftdi_rdn;
  logic       ftdi_wrn;
  logic       ftdi_oen;
  logic [7:0] ftdi_data_i;
  logic [7:0] ftdi_data_o;
  logic       ftdi_data_oe;

  modport master (
    input  ftdi_rxfn,
    input  ftdi_txen,
    input  ftdi_data_o,
    input  ftdi_data_oe,
    output ftdi_rdn,
    output ftdi_wrn,
    output ftdi_oen,
    output ftdi_data_i
  );

  modport slave (
    output ftdi_rxfn,
    output ftdi_txen,
    output ftdi_data_o,
    output ftdi_data_oe,
    input  ftdi_rdn,
    input  ftdi_wrn,
    input  ftdi_oen,
    input  ftdi_data_i
  );
endinterface

// File: rtl/ft245_sync_responder.sv
// Device-end model of the FT245 synchronous FIFO bus: an RX FIFO loaded by the
// host and read by the bus master, a TX FIFO written by the bus master and drained by the host.
module ft245_sync_responder #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ft245_sync_responder_if.slave bus,
  input  logic                  host_wr_en,
  input  logic [7:0]            host_wr_data,
  output logic                  host_full,
  input  logic                  host_rd_en,
  output logic [7:0]            host_rd_data,
  output logic                  host_empty,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic [DEPTH_LOG2:0]   tx_count,
  output logic [3:0]            err_o,
  input  logic                  clr_err_i
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [7:0]            rx_mem [DEPTH];
  logic [7:0]            tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [DEPTH_LOG2-1:0] tx_wr_ptr, tx_rd_ptr;

  logic oe_q;
  logic rxfn_q;
  logic txen_q;

  logic rd_req, wr_req;
  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rx_push, rx_pop, tx_push, tx_pop;
  logic [3:0] err_evt;

  always_comb begin
    rd_req   = ~bus.ftdi_rdn;
    wr_req   = ~bus.ftdi_wrn;
    rx_empty = (rx_count == '0);
    rx_full  = (rx_count == FULL_CNT);
    tx_empty = (tx_count == '0);
    tx_full  = (tx_count == FULL_CNT);

    // Fullness is judged on the pre-edge count, so a push is refused when full
    // even if a pop frees a slot on the same edge.
    rx_push = reset_n & host_wr_en & ~rx_full;
    rx_pop  = reset_n & rd_req & oe_q & ~rx_empty;
    tx_push = reset_n & wr_req & ~oe_q & ~tx_full;
    tx_pop  = reset_n & host_rd_en & ~tx_empty;

    err_evt = {wr_req & oe_q,
               host_wr_en & rx_full,
               wr_req & ~oe_q & tx_full,
               rd_req & oe_q & rx_empty};
  end

  // Storage carries no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= host_wr_data;
    if (tx_push) tx_mem[tx_wr_ptr] <= bus.ftdi_data_i;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + CNT_ONE;
        2'b01:   rx_count <= rx_count - CNT_ONE;
        default: rx_count <= rx_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + CNT_ONE;
        2'b01:   tx_count <= tx_count - CNT_ONE;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // Status flags lag the counts by one cycle, like the real device.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      oe_q   <= 1'b0;
      rxfn_q <= 1'b1;
      txen_q <= 1'b0;
      err_o  <= '0;
    end else begin
      oe_q   <= ~bus.ftdi_oen;
      rxfn_q <= rx_empty;
      txen_q <= tx_full;
      err_o  <= (clr_err_i ? 4'b0000 : err_o) | err_evt;
    end
  end

  assign bus.ftdi_data_oe = oe_q;
  assign bus.ftdi_data_o  = rx_mem[rx_rd_ptr];
  assign bus.ftdi_rxfn    = rxfn_q;
  assign bus.ftdi_txen    = txen_q;

  assign host_full    = rx_full;
  assign host_empty   = tx_empty;
  assign host_rd_data = tx_mem[tx_rd_ptr];

endmodule

// File: tb/tb_ft245_sync_responder.sv
// Bench for ft245_sync_responder: directed vector table, hand sequences and
// randomized traffic against a queue-based reference model.
module tb_ft245_sync_responder;
  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          host_wr_en, host_rd_en, clr_err_i;
  logic [7:0]    host_wr_data, host_rd_data;
  logic          host_full, host_empty;
  logic [DL:0]   rx_count, tx_count;
  logic [3:0]    err_o;

  ft245_sync_responder_if bus();

  ft245_sync_responder #(.DEPTH_LOG2(DL)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .host_wr_en   (host_wr_en),
    .host_wr_data (host_wr_data),
    .host_full    (host_full),
    .host_rd_en   (host_rd_en),
    .host_rd_data (host_rd_data),
    .host_empty   (host_empty),
    .rx_count     (rx_count),
    .tx_count     (tx_count),
    .err_o        (err_o),
    .clr_err_i    (clr_err_i)
  );

  typedef struct {
    logic       rst_n, oen, rdn, wrn;
    logic [7:0] di;
    logic       hw;
    logic [7:0] hd;
    logic       hr, clr;
  } in_t;

  typedef struct {
    in_t        in;
    int         rxc, txc;
    logic [3:0] err;
    logic       oe, rxfn, txen;
    int         dout;   // -1: not checked
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_rx[$];
  logic [7:0] m_tx[$];
  logic [3:0] m_err  = 4'h0;
  logic       m_oe   = 1'b0;
  logic       m_rxfn = 1'b1;
  logic       m_txen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t idle();
    in_t v;
    v.rst_n = 1'b1; v.oen = 1'b1; v.rdn = 1'b1; v.wrn = 1'b1;
    v.di = 8'h00; v.hw = 1'b0; v.hd = 8'h00; v.hr = 1'b0; v.clr = 1'b0;
    return v;
  endfunction

  function automatic vec_t row(input logic rst, oen, rdn, wrn, input logic [7:0] di,
                               input logic hw, input logic [7:0] hd, input logic hr, clr,
                               input int rxc, txc, input logic [3:0] err,
                               input logic oe, rxfn, txen, input int dout);
    vec_t r;
    r.in.rst_n = rst; r.in.oen = oen; r.in.rdn = rdn; r.in.wrn = wrn; r.in.di = di;
    r.in.hw = hw; r.in.hd = hd; r.in.hr = hr; r.in.clr = clr;
    r.rxc = rxc; r.txc = txc; r.err = err; r.oe = oe; r.rxfn = rxfn; r.txen = txen;
    r.dout = dout;
    return r;
  endfunction

  task automatic drive(input in_t v);
    reset_n          = v.rst_n;
    bus.ftdi_oen     = v.oen;
    bus.ftdi_rdn     = v.rdn;
    bus.ftdi_wrn     = v.wrn;
    bus.ftdi_data_i  = v.di;
    host_wr_en       = v.hw;
    host_wr_data     = v.hd;
    host_rd_en       = v.hr;
    clr_err_i        = v.clr;
  endtask

  // Reference behaviour from the bus rules, evaluated on the pre-edge state.
  task automatic model_step(input in_t v);
    int  rxn, txn;
    logic oe, under, ovf, txovr, cont;
    rxn = m_rx.size();
    txn = m_tx.size();
    oe  = m_oe;
    if (!v.rst_n) begin
      m_rx.delete(); m_tx.delete();
      m_err = 4'h0; m_oe = 1'b0; m_rxfn = 1'b1; m_txen = 1'b0;
      return;
    end
    under = !v.rdn && oe && rxn == 0;
    ovf   = v.hw && rxn == DEPTH;
    txovr = !v.wrn && !oe && txn == DEPTH;
    cont  = !v.wrn && oe;
    if (!v.rdn && oe && rxn > 0) void'(m_rx.pop_front());
    if (v.hw && rxn < DEPTH)     m_rx.push_back(v.hd);
    if (v.hr && txn > 0)         void'(m_tx.pop_front());
    if (!v.wrn && !oe && txn < DEPTH) m_tx.push_back(v.di);
    m_err  = (v.clr ? 4'h0 : m_err) | {cont, ovf, txovr, under};
    m_rxfn = (rxn == 0);
    m_txen = (txn == DEPTH);
    m_oe   = !v.oen;
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".rx_count"},   32'(rx_count), m_rx.size());
    chk({tag, ".tx_count"},   32'(tx_count), m_tx.size());
    chk({tag, ".err_o"},      32'(err_o), 32'(m_err));
    chk({tag, ".data_oe"},    32'(bus.ftdi_data_oe), 32'(m_oe));
    chk({tag, ".rxfn"},       32'(bus.ftdi_rxfn), 32'(m_rxfn));
    chk({tag, ".txen"},       32'(bus.ftdi_txen), 32'(m_txen));
    chk({tag, ".host_full"},  32'(host_full), 32'(m_rx.size() == DEPTH));
    chk({tag, ".host_empty"}, 32'(host_empty), 32'(m_tx.size() == 0));
    if (m_rx.size() > 0) chk({tag, ".data_o"}, 32'(bus.ftdi_data_o), 32'(m_rx[0]));
    if (m_tx.size() > 0) chk({tag, ".host_rd_data"}, 32'(host_rd_data), 32'(m_tx[0]));
  endtask

  task automatic step(input in_t v, input string tag);
    drive(v);
    model_step(v);
    @(posedge clk);
    #1;
    model_check(tag);
  endtask

  vec_t vecs[18];

  initial begin
    in_t v;
    string t;

    // rst oen rdn wrn di  hw hd  hr clr | rxc txc err oe rxfn txen dout
    vecs[0]  = row(0,1,1,1,8'h00,0,8'h00,0,0, 0,0,4'h0,0,1,0,-1);
    vecs[1]  = row(1,1,1,1,8'h00,1,8'h11,0,0, 1,0,4'h0,0,1,0,'h11);
    vecs[2]  = row(1,1,1,1,8'h00,1,8'h22,0,0, 2,0,4'h0,0,0,0,'h11);
    vecs[3]  = row(1,1,1,1,8'h00,1,8'h33,0,0, 3,0,4'h0,0,0,0,'h11);
    vecs[4]  = row(1,0,1,1,8'h00,0,8'h00,0,0, 3,0,4'h0,1,0,0,'h11);
    vecs[5]  = row(1,0,0,1,8'h00,0,8'h00,0,0, 2,0,4'h0,1,0,0,'h22);
    vecs[6]  = row(1,0,0,1,8'h00,0,8'h00,0,0, 1,0,4'h0,1,0,0,'h33);
    vecs[7]  = row(1,0,0,1,8'h00,0,8'h00,0,0, 0,0,4'h0,1,0,0,-1);
    vecs[8]  = row(1,0,1,1,8'h00,0,8'h00,0,0, 0,0,4'h0,1,1,0,-1);
    vecs[9]  = row(1,0,0,1,8'h00,0,8'h00,0,0, 0,0,4'h1,1,1,0,-1);
    vecs[10] = row(1,0,1,1,8'h00,0,8'h00,0,1, 0,0,4'h0,1,1,0,-1);
    vecs[11] = row(1,0,1,0,8'hA5,0,8'h00,0,0, 0,0,4'h8,1,1,0,-1);
    vecs[12] = row(1,1,1,1,8'h00,0,8'h00,0,1, 0,0,4'h0,0,1,0,-1);
    vecs[13] = row(1,0,1,1,8'h00,0,8'h00,0,0, 0,0,4'h0,1,1,0,-1);
    vecs[14] = row(1,0,0,0,8'h5A,0,8'h00,0,1, 0,0,4'h9,1,1,0,-1);
    vecs[15] = row(1,1,1,1,8'h00,0,8'h00,0,1, 0,0,4'h0,0,1,0,-1);
    vecs[16] = row(1,1,1,0,8'hC3,0,8'h00,0,0, 0,1,4'h0,0,1,0,-1);
    vecs[17] = row(1,1,1,1,8'h00,0,8'h00,1,0, 0,0,4'h0,0,1,0,-1);

    drive(idle());
    for (int i = 0; i < 18; i++) begin
      t = $sformatf("vec%0d", i);
      step(vecs[i].in, t);
      chk({t, ".rxc"},  32'(rx_count), vecs[i].rxc);
      chk({t, ".txc"},  32'(tx_count), vecs[i].txc);
      chk({t, ".err"},  32'(err_o), 32'(vecs[i].err));
      chk({t, ".oe"},   32'(bus.ftdi_data_oe), 32'(vecs[i].oe));
      chk({t, ".rxfn"}, 32'(bus.ftdi_rxfn), 32'(vecs[i].rxfn));
      chk({t, ".txen"}, 32'(bus.ftdi_txen), 32'(vecs[i].txen));
      if (vecs[i].dout >= 0) chk({t, ".dout"}, 32'(bus.ftdi_data_o), vecs[i].dout);
    end

    // Bus writes 17 bytes into a 16-deep TX FIFO; the last is dropped.
    for (int i = 0; i <= DEPTH; i++) begin
      v = idle(); v.wrn = 1'b0; v.di = 8'(i);
      t = $sformatf("txfill%0d", i);
      step(v, t);
      chk({t, ".cnt"},  32'(tx_count), (i + 1 > DEPTH) ? DEPTH : i + 1);
      chk({t, ".txen"}, 32'(bus.ftdi_txen), 32'(i == DEPTH));
      chk({t, ".ovr"},  32'(err_o[1]), 32'(i == DEPTH));
    end
    for (int i = 0; i < DEPTH; i++) begin
      t = $sformatf("txdrain%0d", i);
      chk({t, ".data"}, 32'(host_rd_data), i);
      v = idle(); v.hr = 1'b1;
      step(v, t);
    end
    chk("txdrain.empty", 32'(host_empty), 1);
    v = idle(); v.clr = 1'b1;
    step(v, "clr1");
    chk("clr1.err", 32'(err_o), 0);

    // 15 bytes resident, push and pop every cycle across pointer wraps.
    for (int n = 0; n < 15; n++) begin
      v = idle(); v.hw = 1'b1; v.hd = 8'(n);
      step(v, "rxload");
    end
    v = idle(); v.oen = 1'b0;
    step(v, "rxoe");
    for (int j = 1; j <= 40; j++) begin
      v = idle(); v.oen = 1'b0; v.rdn = 1'b0; v.hw = 1'b1; v.hd = 8'(14 + j);
      t = $sformatf("rxstream%0d", j);
      step(v, t);
      chk({t, ".cnt"},  32'(rx_count), 15);
      chk({t, ".head"}, 32'(bus.ftdi_data_o), j);
    end

    // Reset with both FIFOs holding data and every strobe active.
    v = idle();
    step(v, "prerst");
    for (int n = 0; n < 5; n++) begin
      v = idle(); v.wrn = 1'b0; v.di = 8'(8'hE0 + n);
      step(v, "txload5");
    end
    v = idle(); v.rst_n = 1'b0; v.oen = 1'b0; v.rdn = 1'b0; v.wrn = 1'b0;
    v.hw = 1'b1; v.hd = 8'h77; v.hr = 1'b1; v.clr = 1'b0;
    step(v, "midrst");
    chk("midrst.rxc",   32'(rx_count), 0);
    chk("midrst.txc",   32'(tx_count), 0);
    chk("midrst.err",   32'(err_o), 0);
    chk("midrst.oe",    32'(bus.ftdi_data_oe), 0);
    chk("midrst.rxfn",  32'(bus.ftdi_rxfn), 1);
    chk("midrst.txen",  32'(bus.ftdi_txen), 0);
    chk("midrst.empty", 32'(host_empty), 1);
    chk("midrst.full",  32'(host_full), 0);
    v = idle(); v.hr = 1'b1;
    step(v, "postrst");
    chk("postrst.txc",   32'(tx_count), 0);
    chk("postrst.empty", 32'(host_empty), 1);

    // Randomized traffic in fill / drain / mixed phases.
    v = idle(); v.rst_n = 1'b0;
    step(v, "rndrst");
    for (int c = 0; c < 3000; c++) begin
      int ph;
      ph = (c / 250) % 3;
      v.rst_n = ($urandom_range(0, 399) != 0);
      v.oen   = ($urandom_range(0, 9) < ((ph == 1) ? 3 : 6));
      v.rdn   = ($urandom_range(0, 9) < ((ph == 1) ? 2 : 6));
      v.wrn   = ($urandom_range(0, 9) < ((ph == 0) ? 2 : 6));
      v.di    = 8'($urandom);
      v.hw    = ($urandom_range(0, 9) < ((ph == 0) ? 8 : (ph == 1) ? 2 : 5));
      v.hd    = 8'($urandom);
      v.hr    = ($urandom_range(0, 9) < ((ph == 0) ? 2 : (ph == 1) ? 8 : 5));
      v.clr   = ($urandom_range(0, 15) == 0);
      step(v, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ft245_sync_responder.md
FT245_SYNC_RESPONDER -- requirements
Module: ft245_sync_responder

Purpose: synthesizable device-end (FTDI-side) model of the FT245-style synchronous FIFO bus; answers the FPGA-side bridge for on-chip loopback self-test and benches.

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, log2 of depth of each internal FIFO (RX: host->bus, TX: bus->host).
REQ-002 SHALL have one clock and a synchronous active-low reset: clk  in  1  sole clock (ftdi_clk domain); all logic on rising edge.
REQ-003 SHALL have reset_n  in  1  synchronous reset, active-low.
REQ-004 SHALL have ftdi_rxfn  out  1  low = RX FIFO holds data for the bus master.
REQ-005 SHALL have ftdi_txen  out  1  low = TX FIFO can accept a bus write.
REQ-006 SHALL have ftdi_rdn, ftdi_wrn, ftdi_oen  in  1 each  active-low read strobe, write strobe, output-enable request from the bus master.
REQ-007 SHALL have ftdi_data_i  in  8  bus write data; ftdi_data_o  out  8  bus read data; ftdi_data_oe  out  1  responder drives the bus.
REQ-008 SHALL have host_wr_en  in  1, host_wr_data  in  8, host_full  out  1  RX FIFO load port.
REQ-009 SHALL have host_rd_en  in  1, host_rd_data  out  8, host_empty  out  1  TX FIFO drain port, first-word-fall-through.
REQ-010 SHALL have rx_count, tx_count  out  DEPTH_LOG2+1 each  occupancy.
REQ-011 SHALL have err_o  out  4  sticky flags {contention, host_ovf, tx_overrun, rx_underrun} as [3:0]; clr_err_i  in  1  clears err_o.

Function
REQ-012 oe_q SHALL be ~ftdi_oen registered; ftdi_data_oe SHALL equal oe_q (bus driven one cycle after OE sampled low, released one cycle after OE sampled high).
REQ-013 ftdi_data_o SHALL always present the RX FIFO head; value undefined-but-stable (hold last) when empty.
REQ-014 RX pop SHALL occur on an edge where ftdi_rdn=0, oe_q=1 and rx_count>0; head advances, ftdi_data_o shows next entry the following cycle.
REQ-015 ftdi_rdn=0 with oe_q=1 and rx_count=0 SHALL pop nothing and set err_o[0].
REQ-016 ftdi_rdn=0 with oe_q=0 SHALL be ignored (no pop, no error).
REQ-017 ftdi_rxfn SHALL be registered: high in the cycle after rx_count becomes 0, low in the cycle after it becomes nonzero.
REQ-018 TX push SHALL occur on an edge where ftdi_wrn=0, oe_q=0 and tx_count<2**DEPTH_LOG2, storing ftdi_data_i.
REQ-019 ftdi_wrn=0 while TX full SHALL drop the byte and set err_o[1].
REQ-020 ftdi_wrn=0 while oe_q=1 SHALL drop the byte and set err_o[3]; ftdi_rdn=0 and ftdi_wrn=0 on the same edge with oe_q=1 SHALL perform only the pop and set err_o[3].
REQ-021 ftdi_txen SHALL be registered: high the cycle after tx_count reaches full, low the cycle after it drops below full.
REQ-022 host_wr_en with RX full SHALL drop the byte and set err_o[2]; host_full = (rx_count==2**DEPTH_LOG2), combinational from count.
REQ-023 host_rd_en with TX empty SHALL be ignored; host_empty = (tx_count==0); host_rd_data = TX head.
REQ-024 Simultaneous push and pop on the same FIFO SHALL both take effect; count unchanged; allowed when full (pop frees slot same edge for host_wr only if not full at sample: push SHALL be rejected when full at sample time).
REQ-025 Pointers SHALL be DEPTH_LOG2 bits and wrap modulo depth; counts SHALL never exceed 2**DEPTH_LOG2 nor underflow.
REQ-026 clr_err_i SHALL clear err_o next edge; an error event on the same edge SHALL win (flag set).
REQ-027 FIFO storage SHALL be inferred RAM/registers without reset; only pointers, counts, flags reset.

Reset
REQ-028 With reset_n=0 at an edge: pointers and counts 0, err_o=0, oe_q=0, ftdi_data_oe=0, ftdi_rxfn=1, ftdi_txen=0, host_empty=1, host_full=0.
REQ-029 Reset mid-transfer SHALL discard both FIFOs' contents; strobes during reset SHALL have no effect.

Verification
REQ-030 Load 0x11,0x22,0x33 via host port; OE low, RD low 3 cycles -> data_oe high one cycle after OE, bytes 0x11,0x22,0x33 in order, rxf_n high one cycle after third pop, err_o=0.
REQ-031 DEPTH_LOG2=4: bus-write 17 bytes 0x00..0x10 -> first 16 stored, txe_n high after 16th, 0x10 dropped, err_o[1]=1; host drains 0x00..0x0F.
REQ-032 RD low with OE low and RX empty -> no data change, err_o[0]=1; clr_err_i pulse -> err_o=0 next cycle.
REQ-033 WR low while oe_q=1 with data 0xA5 -> tx_count stays 0, err_o[3]=1.
REQ-034 RX holding 15 bytes, host_wr_en and bus pop on same edge, repeated 40 cycles -> rx_count stays 15, order preserved across pointer wrap.
REQ-035 Reset asserted with 5 bytes in each FIFO and strobes active -> all reset values of REQ-028, subsequent reads see empty.
